memory_controller: RTL and testbench
====================================

Name: memory_controller

Overview:
- Parameterised arbiter and relay between NUM_CONSUMERS requesters (LSUs or warp fetchers) and NUM_CHANNELS memory ports.
- Each channel independently claims one pending consumer request, forwards it to memory, and relays the response or acknowledgement back.
- Instantiated twice at GPU top: once for data memory (read/write) and once for instruction memory (read-only, WRITE_ENABLE=0).

Parameters:
- DATA_WIDTH, 16: width of read and write data words.
- ADDRESS_WIDTH, 8: width of memory addresses.
- NUM_CONSUMERS, 4: number of requesting consumers.
- NUM_CHANNELS, 1: number of concurrent memory channels.
- WRITE_ENABLE, 1: 0 disables all write servicing.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request.
- consumer_read_address  in  [NUM_CONSUMERS] x ADDRESS_WIDTH  read address.
- consumer_read_ready  out  NUM_CONSUMERS  read data valid for the consumer.
- consumer_read_data  out  [NUM_CONSUMERS] x DATA_WIDTH  returned read data.
- consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request.
- consumer_write_address  in  [NUM_CONSUMERS] x ADDRESS_WIDTH  write address.
- consumer_write_data  in  [NUM_CONSUMERS] x DATA_WIDTH  write data.
- consumer_write_ready  out  NUM_CONSUMERS  write acknowledged.
- mem_read_valid  out  NUM_CHANNELS  channel read request to memory.
- mem_read_address  out  [NUM_CHANNELS] x ADDRESS_WIDTH  read address to memory.
- mem_read_ready  in  NUM_CHANNELS  memory read complete.
- mem_read_data  in  [NUM_CHANNELS] x DATA_WIDTH  memory read data.
- mem_write_valid  out  NUM_CHANNELS  channel write request to memory.
- mem_write_address  out  [NUM_CHANNELS] x ADDRESS_WIDTH  write address to memory.
- mem_write_data  out  [NUM_CHANNELS] x DATA_WIDTH  write data to memory.
- mem_write_ready  in  NUM_CHANNELS  memory write complete.

Behaviour:
- All outputs are registered.
- reset=0 asynchronously clears every output, all channel states to IDLE, and the claim mask to all zeros. Reset mid-transaction drops in-flight requests.
- A shared claim mask (NUM_CONSUMERS bits) marks consumers being served. A claimed consumer is invisible to other channels.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers from index 0 upward; pick the first unclaimed consumer with read_valid or write_valid.
  - Read has priority over write for the same consumer.
  - Set the claim bit and latch the consumer index.
  - Read: mem_read_valid<=1, mem_read_address<=consumer address, go READ_WAITING.
  - Write: mem_write_valid<=1, drive address and data, go WRITE_WAITING.
  - Channels evaluate in ascending index within one cycle, and claims made by lower channels are visible to higher ones (no double claim).
- READ_WAITING: on mem_read_ready, mem_read_valid<=0, consumer_read_data[c]<=mem_read_data, consumer_read_ready[c]<=1, go READ_RELAYING. Otherwise hold.
- WRITE_WAITING: on mem_write_ready, mem_write_valid<=0, consumer_write_ready[c]<=1, go WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING:
  - Hold ready until the consumer deasserts its corresponding valid.
  - Then ready<=0, clear the claim bit, go IDLE.
  - The consumer can be re-claimed no earlier than the following cycle.
- Latency: consumer valid sampled at edge N gives mem valid at N+1. A memory ready seen at edge M gives consumer ready at M+1.
- Handshake: a consumer must hold valid and address/data stable until ready. Dropping valid while in WAITING does not abort; the access completes and ready is relayed.
- WRITE_ENABLE=0: write requests are ignored; mem_write_valid, mem_write_address, mem_write_data and consumer_write_ready stay 0; mem_write_ready is unused.
- More pending consumers than free channels: the excess wait, and the lowest indices are served first. There is no fairness guarantee.
- consumer_read_data[c] retains its last value after ready drops.

Decomposition:
- Shared package holds DATA_WIDTH/ADDRESS_WIDTH defaults, data_t, data_memory_address_t, instruction_t, instruction_memory_address_t, and the channel state enum.
- Single module. Claim arbitration couples channels, so no per-channel sub-module is used.
- A combinational function for the first-unclaimed-requester search is allowed.

Test Plan:
- Single read: NUM_CHANNELS=1; consumer 2 reads addr 0x10; memory answers 0xBEEF after 3 cycles. Expect mem_read_valid=1 with addr 0x10 one cycle after the request, consumer_read_ready[2]=1 with data 0xBEEF one cycle after mem_read_ready, and the channel back in IDLE after valid drops.
- Single write: consumer 0 writes 0x1234 to addr 0x05. Expect mem_write_valid=1 with addr 0x05 and data 0x1234, then consumer_write_ready[0]=1; ready deasserts one cycle after write_valid falls.
- Contention: 4 consumers, 2 channels, all reading simultaneously. Expect consumers 0 and 1 served first on channels 0 and 1 respectively, then 2 and 3; no consumer served twice; all four return correct data.
- Read priority: consumer 1 asserts read and write together. Expect the read issued first and the write issued only after the read handshake completes.
- WRITE_ENABLE=0: consumer 0 write_valid held 20 cycles. Expect mem_write_valid and consumer_write_ready to stay 0; reads still serviced normally.
- Async reset: assert reset=0 while in READ_WAITING, between clock edges. Expect all outputs 0 immediately; after release, a new request is claimed normally.

Source files
------------

// File: rtl/memory_controller_pkg.sv
// Shared types and width defaults for the memory controller and the GPU
// blocks that talk to data and instruction memory.
package memory_controller_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 8;

  typedef logic [DEFAULT_DATA_WIDTH-1:0]    data_t;
  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] data_memory_address_t;
  typedef logic [15:0]                      instruction_t;
  typedef logic [7:0]                       instruction_memory_address_t;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } channel_state_t;

endpackage

// File: rtl/memory_controller_if.sv
// Multi-port read/write request bus. The requester uses master and the
// responder uses slave; PORTS is the number of parallel lanes.
interface memory_controller_if
  import memory_controller_pkg::*;
#(
  parameter int PORTS         = 1,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);

  logic [PORTS-1:0]                    read_valid;
  logic [PORTS-1:0][ADDRESS_WIDTH-1:0] read_address;
  logic [PORTS-1:0]                    read_ready;
  logic [PORTS-1:0][DATA_WIDTH-1:0]    read_data;
  logic [PORTS-1:0]                    write_valid;
  logic [PORTS-1:0][ADDRESS_WIDTH-1:0] write_address;
  logic [PORTS-1:0][DATA_WIDTH-1:0]    write_data;
  logic [PORTS-1:0]                    write_ready;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );

endinterface

// File: rtl/memory_controller.sv
// Arbitrates NUM_CONSUMERS requesters onto NUM_CHANNELS memory ports; each
// channel claims one consumer, forwards its access and relays the response.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input logic                 clk,
  input logic                 reset,
  memory_controller_if.slave  consumer,
  memory_controller_if.master mem
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  channel_state_t state_q [NUM_CHANNELS];
  channel_state_t state_d [NUM_CHANNELS];
  idx_t           owner_q [NUM_CHANNELS];
  idx_t           owner_d [NUM_CHANNELS];

  logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
  logic [NUM_CHANNELS-1:0]  mem_rd_valid_q, mem_rd_valid_d;
  logic [NUM_CHANNELS-1:0]  mem_wr_valid_q, mem_wr_valid_d;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [NUM_CHANNELS-1:0][ADDRESS_WIDTH-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    mem_wr_data_q, mem_wr_data_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [NUM_CONSUMERS-1:0] wr_req;
  logic [NUM_CONSUMERS-1:0] taken;
  logic [NUM_CONSUMERS-1:0] req;
  logic [IDX_W:0]           hit;
  idx_t                     sel;
  idx_t                     own;

  // {found, index} of the lowest set bit
  function automatic logic [IDX_W:0] first_set(input logic [NUM_CONSUMERS-1:0] vec);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
      if (vec[i]) r = {1'b1, idx_t'(i)};
    end
    return r;
  endfunction

  assign wr_req = (WRITE_ENABLE != 0) ? consumer.write_valid : '0;

  // Releases only reach claim_d; newly free consumers stay hidden from
  // idle channels until the next cycle because the search uses 'taken'.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    claim_d        = claim_q;
    taken          = claim_q;
    mem_rd_valid_d = mem_rd_valid_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    mem_wr_valid_d = mem_wr_valid_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    rd_ready_d     = rd_ready_q;
    wr_ready_d     = wr_ready_q;
    rd_data_d      = rd_data_q;
    req            = '0;
    hit            = '0;
    sel            = '0;
    own            = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      own = owner_q[ch];
      case (state_q[ch])
        IDLE: begin
          req = (consumer.read_valid | wr_req) & ~taken;
          hit = first_set(req);
          if (hit[IDX_W]) begin
            sel          = hit[IDX_W-1:0];
            taken[sel]   = 1'b1;
            claim_d[sel] = 1'b1;
            owner_d[ch]  = sel;
            if (consumer.read_valid[sel]) begin
              mem_rd_valid_d[ch] = 1'b1;
              mem_rd_addr_d[ch]  = consumer.read_address[sel];
              state_d[ch]        = READ_WAITING;
            end else begin
              mem_wr_valid_d[ch] = 1'b1;
              mem_wr_addr_d[ch]  = consumer.write_address[sel];
              mem_wr_data_d[ch]  = consumer.write_data[sel];
              state_d[ch]        = WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem.read_ready[ch]) begin
            mem_rd_valid_d[ch] = 1'b0;
            rd_data_d[own]     = mem.read_data[ch];
            rd_ready_d[own]    = 1'b1;
            state_d[ch]        = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem.write_ready[ch]) begin
            mem_wr_valid_d[ch] = 1'b0;
            wr_ready_d[own]    = 1'b1;
            state_d[ch]        = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer.read_valid[own]) begin
            rd_ready_d[own] = 1'b0;
            claim_d[own]    = 1'b0;
            state_d[ch]     = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer.write_valid[own]) begin
            wr_ready_d[own] = 1'b0;
            claim_d[own]    = 1'b0;
            state_d[ch]     = IDLE;
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= IDLE;
        owner_q[ch] <= '0;
      end
      claim_q        <= '0;
      mem_rd_valid_q <= '0;
      mem_rd_addr_q  <= '0;
      mem_wr_valid_q <= '0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      rd_ready_q     <= '0;
      wr_ready_q     <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      claim_q        <= claim_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      rd_ready_q     <= rd_ready_d;
      wr_ready_q     <= wr_ready_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign mem.read_valid      = mem_rd_valid_q;
  assign mem.read_address    = mem_rd_addr_q;
  assign mem.write_valid     = mem_wr_valid_q;
  assign mem.write_address   = mem_wr_addr_q;
  assign mem.write_data      = mem_wr_data_q;
  assign consumer.read_ready  = rd_ready_q;
  assign consumer.read_data   = rd_data_q;
  assign consumer.write_ready = wr_ready_q;

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: a 2-channel read/write instance and a
// 1-channel read-only instance, directed steps then randomized traffic.
module tb_memory_controller;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  memory_controller_if #(.PORTS(4)) ca ();
  memory_controller_if #(.PORTS(2)) ma ();
  memory_controller_if #(.PORTS(4)) cb ();
  memory_controller_if #(.PORTS(1)) mb ();

  memory_controller #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_CONSUMERS(4),
    .NUM_CHANNELS(2), .WRITE_ENABLE(1)
  ) dut_a (.clk(clk), .reset(reset), .consumer(ca), .mem(ma));

  memory_controller #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(8), .NUM_CONSUMERS(4),
    .NUM_CHANNELS(1), .WRITE_ENABLE(0)
  ) dut_b (.clk(clk), .reset(reset), .consumer(cb), .mem(mb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Contents of the modelled memory: every address holds a fixed word
  function automatic logic [15:0] model_word(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // randomized-phase consumer and memory model state
  bit          busy      [4];
  bit          is_wr     [4];
  bit          mem_seen  [4];
  logic [7:0]  r_addr    [4];
  logic [15:0] r_data    [4];
  int          rlat      [2];
  int          wlat      [2];
  int          issued    = 0;
  int          completed = 0;
  int          pending;
  logic [1:0]  c;
  logic [31:0] seen;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ca.read_valid = '0; ca.read_address = '0; ca.write_valid = '0;
    ca.write_address = '0; ca.write_data = '0;
    cb.read_valid = '0; cb.read_address = '0; cb.write_valid = '0;
    cb.write_address = '0; cb.write_data = '0;
    ma.read_ready = '0; ma.read_data = '0; ma.write_ready = '0;
    mb.read_ready = '0; mb.read_data = '0; mb.write_ready = '0;
    reset = 1'b0;
    repeat (3) tick();

    check("rst_flags", 32'({ma.read_valid, ma.write_valid, ca.read_ready, ca.write_ready,
                            mb.read_valid, mb.write_valid, cb.read_ready, cb.write_ready}), 0);
    check("rst_data", 32'(|{ca.read_data, cb.read_data, ma.read_address, ma.write_data}), 0);
    reset = 1'b1;
    tick();

    // single read through the one-channel instance
    cb.read_address[2] = 8'h10; cb.read_valid[2] = 1'b1;
    tick();
    check("sr_mem_valid", 32'(mb.read_valid), 1);
    check("sr_mem_addr", 32'(mb.read_address[0]), 32'h10);
    tick(); tick();
    check("sr_no_early_ready", 32'(cb.read_ready), 0);
    mb.read_data[0] = 16'hBEEF; mb.read_ready[0] = 1'b1;
    tick();
    mb.read_ready[0] = 1'b0;
    check("sr_ready", 32'(cb.read_ready), 32'b0100);
    check("sr_data", 32'(cb.read_data[2]), 32'hBEEF);
    check("sr_mem_valid_drop", 32'(mb.read_valid), 0);
    tick();
    check("sr_ready_hold", 32'(cb.read_ready), 32'b0100);
    cb.read_valid[2] = 1'b0;
    tick();
    check("sr_ready_drop", 32'(cb.read_ready), 0);
    check("sr_data_retained", 32'(cb.read_data[2]), 32'hBEEF);
    cb.read_address[0] = 8'h11; cb.read_valid[0] = 1'b1;
    tick();
    check("sr_reclaim", 32'({mb.read_valid, mb.read_address[0]}), 32'h111);
    mb.read_data[0] = 16'h0011; mb.read_ready[0] = 1'b1;
    tick();
    mb.read_ready[0] = 1'b0;
    check("sr2_ready_data", 32'({cb.read_ready, cb.read_data[0]}), 32'h10011);
    cb.read_valid[0] = 1'b0;
    tick();

    // single write
    ca.write_address[0] = 8'h05; ca.write_data[0] = 16'h1234; ca.write_valid[0] = 1'b1;
    tick();
    check("sw_mem_valid", 32'({ma.write_valid, ma.read_valid}), 32'b0100);
    check("sw_mem_addr_data", 32'({ma.write_address[0], ma.write_data[0]}), 32'h051234);
    tick();
    ma.write_ready[0] = 1'b1;
    tick();
    ma.write_ready[0] = 1'b0;
    check("sw_ack", 32'({ca.write_ready, ma.write_valid}), 32'b000100);
    ca.write_valid[0] = 1'b0;
    tick();
    check("sw_ack_drop", 32'(ca.write_ready), 0);

    // contention: four readers, two channels
    for (int i = 0; i < 4; i++) begin
      ca.read_address[i] = 8'(8'h20 + i);
      ca.read_valid[i]   = 1'b1;
    end
    tick();
    check("ct_first_valid", 32'(ma.read_valid), 32'b11);
    check("ct_first_addr", 32'({ma.read_address[1], ma.read_address[0]}), 32'h2120);
    ma.read_data[0] = 16'hA020; ma.read_data[1] = 16'hA021; ma.read_ready = 2'b11;
    tick();
    ma.read_ready = 2'b00;
    check("ct_first_ready", 32'({ca.read_ready, ma.read_valid}), 32'b001100);
    check("ct_first_data", {ca.read_data[1], ca.read_data[0]}, 32'hA021A020);
    ca.read_valid[0] = 1'b0; ca.read_valid[1] = 1'b0;
    tick();
    check("ct_gap", 32'({ca.read_ready, ma.read_valid}), 0);
    tick();
    check("ct_second_valid", 32'(ma.read_valid), 32'b11);
    check("ct_second_addr", 32'({ma.read_address[1], ma.read_address[0]}), 32'h2322);
    ma.read_data[0] = 16'hA022; ma.read_data[1] = 16'hA023; ma.read_ready = 2'b11;
    tick();
    ma.read_ready = 2'b00;
    check("ct_second_ready", 32'(ca.read_ready), 32'b1100);
    check("ct_second_data", {ca.read_data[3], ca.read_data[2]}, 32'hA023A022);
    ca.read_valid[2] = 1'b0; ca.read_valid[3] = 1'b0;
    tick();
    tick();
    check("ct_quiet", 32'({ca.read_ready, ma.read_valid}), 0);

    // read beats write for the same consumer
    ca.read_address[1] = 8'h30; ca.write_address[1] = 8'h31; ca.write_data[1] = 16'h5555;
    ca.read_valid[1] = 1'b1; ca.write_valid[1] = 1'b1;
    tick();
    check("rp_read_first", 32'({ma.read_valid, ma.write_valid, ma.read_address[0]}), 32'h430);
    ma.read_data[0] = 16'h3030; ma.read_ready[0] = 1'b1;
    tick();
    ma.read_ready[0] = 1'b0;
    check("rp_read_ready", 32'({ca.read_ready, ca.write_ready, ma.write_valid}), 32'b0010000000);
    ca.read_valid[1] = 1'b0;
    tick();
    check("rp_write_not_yet", 32'(ma.write_valid), 0);
    tick();
    check("rp_write_issued", 32'({ma.write_valid, ma.write_address[0], ma.write_data[0]}), 32'h1315555);
    ma.write_ready[0] = 1'b1;
    tick();
    ma.write_ready[0] = 1'b0;
    check("rp_write_ack", 32'(ca.write_ready), 32'b0010);
    ca.write_valid[1] = 1'b0;
    tick();

    // write disabled instance: writes ignored, reads still served
    cb.write_address[0] = 8'h07; cb.write_data[0] = 16'h7777; cb.write_valid[0] = 1'b1;
    cb.read_address[3] = 8'h44; cb.read_valid[3] = 1'b1;
    tick();
    check("we0_read_issued", 32'({mb.read_valid, mb.write_valid, mb.read_address[0]}), 32'h244);
    mb.read_data[0] = 16'h4444; mb.read_ready[0] = 1'b1;
    tick();
    mb.read_ready[0] = 1'b0;
    check("we0_read_ready", 32'({cb.read_ready, cb.read_data[3]}), 32'h84444);
    cb.read_valid[3] = 1'b0;
    seen = '0;
    for (int k = 0; k < 18; k++) begin
      tick();
      seen = seen | 32'({mb.write_valid, cb.write_ready, mb.write_address[0],
                         mb.write_data[0], mb.read_valid});
    end
    check("we0_no_write", seen, 0);
    cb.write_valid[0] = 1'b0;
    tick();

    // asynchronous reset while a read is waiting
    cb.read_address[1] = 8'h55; cb.read_valid[1] = 1'b1;
    tick();
    check("ar_waiting", 32'({mb.read_valid, mb.read_address[0]}), 32'h155);
    #2 reset = 1'b0;
    #1;
    check("ar_flags_clear", 32'({mb.read_valid, mb.read_address[0], cb.read_ready, ma.read_valid}), 0);
    check("ar_data_clear", 32'(|{cb.read_data, ca.read_data, ma.write_data}), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("ar_reclaim", 32'({mb.read_valid, mb.read_address[0]}), 32'h155);
    mb.read_data[0] = 16'h5151; mb.read_ready[0] = 1'b1;
    tick();
    mb.read_ready[0] = 1'b0;
    check("ar_ready", 32'({cb.read_ready, cb.read_data[1]}), 32'h25151);
    cb.read_valid[1] = 1'b0;
    tick();

    // randomized traffic on the two-channel instance
    for (int ch = 0; ch < 2; ch++) begin
      rlat[ch] = -1;
      wlat[ch] = -1;
    end
    for (int i = 0; i < 4; i++) begin
      busy[i] = 1'b0; is_wr[i] = 1'b0; mem_seen[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 1200; cyc++) begin
      tick();
      for (int ch = 0; ch < 2; ch++) begin
        if (ma.read_ready[ch]) begin
          ma.read_ready[ch] = 1'b0;
        end else if (ma.read_valid[ch]) begin
          if (rlat[ch] < 0) rlat[ch] = $urandom_range(0, 4);
          if (rlat[ch] == 0) begin
            ma.read_data[ch]  = model_word(ma.read_address[ch]);
            ma.read_ready[ch] = 1'b1;
          end
          rlat[ch]--;
        end
        if (ma.write_ready[ch]) begin
          ma.write_ready[ch] = 1'b0;
        end else if (ma.write_valid[ch]) begin
          if (wlat[ch] < 0) wlat[ch] = $urandom_range(0, 4);
          if (wlat[ch] == 0) begin
            c = ma.write_data[ch][15:14];
            check("rnd_wr_match",
                  32'({busy[c], is_wr[c], mem_seen[c], ma.write_address[ch], ma.write_data[ch]}),
                  32'({3'b110, r_addr[c], r_data[c]}));
            mem_seen[c] = 1'b1;
            ma.write_ready[ch] = 1'b1;
          end
          wlat[ch]--;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (busy[i]) begin
          if (!is_wr[i] && ca.read_ready[i]) begin
            check("rnd_rd_data", 32'({ca.write_ready[i], ca.read_data[i]}),
                  32'(model_word(r_addr[i])));
            ca.read_valid[i] = 1'b0;
            busy[i] = 1'b0;
            completed++;
          end else if (is_wr[i] && ca.write_ready[i]) begin
            check("rnd_wr_ack", 32'({ca.read_ready[i], mem_seen[i]}), 1);
            ca.write_valid[i] = 1'b0;
            busy[i] = 1'b0;
            completed++;
          end
        end else begin
          check("rnd_idle_ready", 32'({ca.read_ready[i], ca.write_ready[i]}), 0);
          if (cyc < 1000 && $urandom_range(0, 2) == 0) begin
            is_wr[i]    = 1'($urandom_range(0, 1));
            r_addr[i]   = 8'($urandom);
            r_data[i]   = {2'(i), 14'($urandom)};
            mem_seen[i] = 1'b0;
            busy[i]     = 1'b1;
            issued++;
            if (is_wr[i]) begin
              ca.write_address[i] = r_addr[i];
              ca.write_data[i]    = r_data[i];
              ca.write_valid[i]   = 1'b1;
            end else begin
              ca.read_address[i] = r_addr[i];
              ca.read_valid[i]   = 1'b1;
            end
          end
        end
      end
    end
    pending = 0;
    for (int i = 0; i < 4; i++) pending += int'(busy[i]);
    check("rnd_all_done", 32'(pending), 0);
    check("rnd_completed", 32'(completed), 32'(issued));
    check("rnd_activity", 32'(issued > 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
